lcd_bus_receiver: RTL and testbench



---
 rtl/lcd_bus_receiver_pkg.sv | 32 +++
 rtl/lcd_busy_timer.sv | 33 +++
 rtl/lcd_bus_receiver.sv | 204 ++++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_receiver_pkg.sv
// Shared codes, line-wrap addresses and receiver states for the LCD bus receiver.
package lcd_bus_receiver_pkg;

  localparam logic [7:0] LCD_CLEAR         = 8'h01;
  localparam logic [7:0] LCD_HOME          = 8'h02;
  localparam logic [7:0] LCD_SET_DDRAM     = 8'h80;
  localparam logic [3:0] LCD_FUNC_SET_4BIT = 4'h2;

  localparam logic [6:0] LINE1_END   = 7'h27;
  localparam logic [6:0] LINE2_START = 7'h40;
  localparam logic [6:0] LINE2_END   = 7'h67;
  localparam logic [6:0] ADDR_MAX    = 7'h7F;

  typedef enum logic [1:0] {
    INIT8 = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2
  } rxState_t;

  // Address counter step after a data write, following the two-line wrap.
  function automatic logic [6:0] nextDdramAddr(input logic [6:0] addr);
    logic [6:0] result;
    case (addr)
      LINE1_END: result = LINE2_START;
      LINE2_END: result = 7'h00;
      ADDR_MAX:  result = 7'h00;
      default:   result = addr + 7'd1;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/lcd_busy_timer.sv
// Loadable down-counter modelling the LCD controller busy time.
module lcd_busy_timer #(
  parameter int WIDTH = 17
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iLoadValue,
  output logic             oBusy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_r;

  // Busy is kept registered and equal to (count_r != 0) at every edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_r <= '0;
      oBusy   <= 1'b0;
    end else if (iLoad) begin
      count_r <= iLoadValue;
      oBusy   <= (iLoadValue != '0);
    end else if (count_r != '0) begin
      count_r <= count_r - ONE;
      oBusy   <= (count_r != ONE);
    end else begin
      count_r <= count_r;
      oBusy   <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Listening end of the 4-bit HD44780-style LCD write bus: nibble capture,
// byte reassembly, command decode, DDRAM address tracking and busy modelling.
module lcd_bus_receiver
  import lcd_bus_receiver_pkg::*;
#(
  parameter int BUSY_CYCLES       = 2000,
  parameter int CLEAR_BUSY_CYCLES = 82000,
  parameter int MIN_E_HIGH        = 12
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_ReadWrite,
  input  logic [3:0] iLCD_Data,
  output logic [7:0] oByte,
  output logic       oIsData,
  output logic       oByteValid,
  output logic [6:0] oDDRAMAddr,
  output logic       oFourBitMode,
  output logic       oBusy,
  output logic       oProtocolError
);

  localparam int MAX_BUSY = (CLEAR_BUSY_CYCLES > BUSY_CYCLES) ? CLEAR_BUSY_CYCLES : BUSY_CYCLES;
  localparam int BUSY_W   = $clog2(MAX_BUSY + 1);
  localparam int EHI_W    = $clog2(MIN_E_HIGH + 1);

  localparam logic [BUSY_W-1:0] BUSY_LOAD  = BUSY_W'(BUSY_CYCLES);
  localparam logic [BUSY_W-1:0] CLEAR_LOAD = BUSY_W'(CLEAR_BUSY_CYCLES);
  localparam logic [EHI_W-1:0]  E_MIN      = EHI_W'(MIN_E_HIGH);

  logic             eSync_r, rsSync_r, rwSync_r;
  logic [3:0]       dSync_r;
  logic             eDly_r, rsDly_r, rwDly_r;
  logic [3:0]       dDly_r;
  logic [EHI_W-1:0] eHighCnt_r;

  rxState_t   state_r, stateNext_s;
  logic [3:0] hiNibble_r;
  logic       hiRs_r;

  logic              strobe_s;
  logic              byteFire_s;
  logic [7:0]        byteNext_s;
  logic              isDataNext_s;
  logic              hiCapture_s;
  logic              setFourBit_s;
  logic              errSet_s;
  logic [6:0]        addrNext_s;
  logic [BUSY_W-1:0] busyLoad_s;

  // Bus inputs registered once; the delayed copy holds the values seen while E was high.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      eSync_r  <= 1'b0;
      rsSync_r <= 1'b0;
      rwSync_r <= 1'b0;
      dSync_r  <= 4'h0;
      eDly_r   <= 1'b0;
      rsDly_r  <= 1'b0;
      rwDly_r  <= 1'b0;
      dDly_r   <= 4'h0;
    end else begin
      eSync_r  <= iLCD_Enabled;
      rsSync_r <= iLCD_RegisterSelect;
      rwSync_r <= iLCD_ReadWrite;
      dSync_r  <= iLCD_Data;
      eDly_r   <= eSync_r;
      rsDly_r  <= rsSync_r;
      rwDly_r  <= rwSync_r;
      dDly_r   <= dSync_r;
    end
  end

  // E-high width counter, saturating at the minimum legal width.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      eHighCnt_r <= '0;
    end else if (!eSync_r) begin
      eHighCnt_r <= '0;
    end else if (eHighCnt_r != E_MIN) begin
      eHighCnt_r <= eHighCnt_r + EHI_W'(1);
    end else begin
      eHighCnt_r <= eHighCnt_r;
    end
  end

  assign strobe_s = eDly_r & ~eSync_r;

  // Strobe classification and nibble/byte phase tracking.
  always_comb begin
    stateNext_s  = state_r;
    byteFire_s   = 1'b0;
    byteNext_s   = oByte;
    isDataNext_s = oIsData;
    hiCapture_s  = 1'b0;
    setFourBit_s = 1'b0;
    errSet_s     = 1'b0;
    if (strobe_s) begin
      errSet_s = (eHighCnt_r < E_MIN) | rwDly_r | oBusy;
      if (rwDly_r) begin
        stateNext_s = state_r;
      end else begin
        case (state_r)
          INIT8: begin
            if (rsDly_r) begin
              errSet_s = 1'b1;
            end else begin
              byteFire_s   = 1'b1;
              byteNext_s   = {dDly_r, 4'h0};
              isDataNext_s = 1'b0;
              if (dDly_r == LCD_FUNC_SET_4BIT) begin
                stateNext_s  = HI;
                setFourBit_s = 1'b1;
              end else begin
                stateNext_s = INIT8;
              end
            end
          end
          HI: begin
            hiCapture_s = 1'b1;
            stateNext_s = LO;
          end
          LO: begin
            stateNext_s = HI;
            if (rsDly_r != hiRs_r) begin
              errSet_s = 1'b1;
            end else begin
              byteFire_s   = 1'b1;
              byteNext_s   = {hiNibble_r, dDly_r};
              isDataNext_s = rsDly_r;
            end
          end
          default: stateNext_s = INIT8;
        endcase
      end
    end else begin
      stateNext_s = state_r;
    end
  end

  // Byte decode: next DDRAM address and busy reload value.
  always_comb begin
    addrNext_s = oDDRAMAddr;
    busyLoad_s = BUSY_LOAD;
    if (isDataNext_s) begin
      addrNext_s = nextDdramAddr(oDDRAMAddr);
    end else if (state_r == INIT8) begin
      addrNext_s = oDDRAMAddr;
    end else if ((byteNext_s == LCD_CLEAR) || (byteNext_s[7:1] == LCD_HOME[7:1])) begin
      addrNext_s = 7'h00;
      busyLoad_s = CLEAR_LOAD;
    end else if ((byteNext_s & LCD_SET_DDRAM) != 8'h00) begin
      addrNext_s = byteNext_s[6:0];
    end else begin
      addrNext_s = oDDRAMAddr;
    end
  end

  // Receiver state machine with registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r        <= INIT8;
      hiNibble_r     <= 4'h0;
      hiRs_r         <= 1'b0;
      oByte          <= 8'h00;
      oIsData        <= 1'b0;
      oByteValid     <= 1'b0;
      oDDRAMAddr     <= 7'h00;
      oFourBitMode   <= 1'b0;
      oProtocolError <= 1'b0;
    end else begin
      state_r    <= stateNext_s;
      oByteValid <= byteFire_s;
      if (hiCapture_s) begin
        hiNibble_r <= dDly_r;
        hiRs_r     <= rsDly_r;
      end
      if (byteFire_s) begin
        oByte      <= byteNext_s;
        oIsData    <= isDataNext_s;
        oDDRAMAddr <= addrNext_s;
      end
      if (setFourBit_s) begin
        oFourBitMode <= 1'b1;
      end
      if (errSet_s) begin
        oProtocolError <= 1'b1;
      end
    end
  end

  lcd_busy_timer #(
    .WIDTH(BUSY_W)
  ) busyTimer (
    .Clock      (Clock),
    .Reset      (Reset),
    .iLoad      (byteFire_s),
    .iLoadValue (busyLoad_s),
    .oBusy      (oBusy)
  );

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Scoreboard bench for lcd_bus_receiver: expected bytes queued at stimulus time,
// popped and compared whenever oByteValid pulses.
module tb_lcd_bus_receiver;

  localparam int BUSY_CYC  = 40;
  localparam int CLEAR_CYC = 300;
  localparam int E_HIGH    = 20;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iLCD_Enabled = 1'b0;
  logic       iLCD_RegisterSelect = 1'b0;
  logic       iLCD_ReadWrite = 1'b0;
  logic [3:0] iLCD_Data = 4'h0;
  logic [7:0] oByte;
  logic       oIsData;
  logic       oByteValid;
  logic [6:0] oDDRAMAddr;
  logic       oFourBitMode;
  logic       oBusy;
  logic       oProtocolError;

  int checkCount = 0;
  int errorCount = 0;
  int pushCount  = 0;
  int validCount = 0;
  int busyRun    = 0;
  logic [8:0] sbQueue[$];

  lcd_bus_receiver #(
    .BUSY_CYCLES       (BUSY_CYC),
    .CLEAR_BUSY_CYCLES (CLEAR_CYC),
    .MIN_E_HIGH        (12)
  ) dut (
    .Clock               (Clock),
    .Reset               (Reset),
    .iLCD_Enabled        (iLCD_Enabled),
    .iLCD_RegisterSelect (iLCD_RegisterSelect),
    .iLCD_ReadWrite      (iLCD_ReadWrite),
    .iLCD_Data           (iLCD_Data),
    .oByte               (oByte),
    .oIsData             (oIsData),
    .oByteValid          (oByteValid),
    .oDDRAMAddr          (oDDRAMAddr),
    .oFourBitMode        (oFourBitMode),
    .oBusy               (oBusy),
    .oProtocolError      (oProtocolError)
  );

  always #5 Clock = ~Clock;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard pop on every byte pulse, plus busy-length measurement.
  always @(negedge Clock) begin
    if (oByteValid) begin
      validCount++;
      busyRun = 1;
      if (sbQueue.size() > 0) begin
        checkValue("byte", {23'd0, oIsData, oByte}, {23'd0, sbQueue.pop_front()});
      end
    end else if (oBusy) begin
      busyRun++;
    end
  end

  task automatic pushExpected(input logic isData, input logic [7:0] b);
    sbQueue.push_back({isData, b});
    pushCount++;
  endtask

  task automatic writeNibble(input logic rs, input logic rw, input logic [3:0] d, input int highCycles);
    @(posedge Clock); #1;
    iLCD_RegisterSelect = rs;
    iLCD_ReadWrite      = rw;
    iLCD_Data           = d;
    iLCD_Enabled        = 1'b1;
    repeat (highCycles) @(posedge Clock);
    #1;
    iLCD_Enabled = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    iLCD_ReadWrite = 1'b0;
  endtask

  task automatic sendByte(input logic rs, input logic [7:0] b);
    pushExpected(rs, b);
    writeNibble(rs, 1'b0, b[7:4], E_HIGH);
    writeNibble(rs, 1'b0, b[3:0], E_HIGH);
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while (oBusy && n < maxCycles) begin
      @(negedge Clock);
      n++;
    end
    checkValue("idle", {31'd0, oBusy}, 32'd0);
  endtask

  task automatic doReset();
    @(posedge Clock); #1;
    Reset = 1'b1;
    iLCD_Enabled = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic checkResetState(input string tag);
    checkValue({tag, "_byte"}, {24'd0, oByte}, 32'd0);
    checkValue({tag, "_isdata"}, {31'd0, oIsData}, 32'd0);
    checkValue({tag, "_valid"}, {31'd0, oByteValid}, 32'd0);
    checkValue({tag, "_addr"}, {25'd0, oDDRAMAddr}, 32'd0);
    checkValue({tag, "_4bit"}, {31'd0, oFourBitMode}, 32'd0);
    checkValue({tag, "_busy"}, {31'd0, oBusy}, 32'd0);
    checkValue({tag, "_err"}, {31'd0, oProtocolError}, 32'd0);
  endtask

  initial begin
    doReset();
    checkResetState("rst");

    // Power-on 8-bit init: 3,3,3 then 2 switches to 4-bit mode
    for (int i = 0; i < 4; i++) begin
      logic [3:0] d;
      d = (i == 3) ? 4'h2 : 4'h3;
      pushExpected(1'b0, {d, 4'h0});
      writeNibble(1'b0, 1'b0, d, E_HIGH);
      checkValue("init_4bit", {31'd0, oFourBitMode}, (i == 3) ? 32'd1 : 32'd0);
      waitIdle(BUSY_CYC + 10);
    end
    checkValue("init_err", {31'd0, oProtocolError}, 32'd0);

    sendByte(1'b1, 8'h41);
    checkValue("data_addr", {25'd0, oDDRAMAddr}, 32'd1);
    waitIdle(BUSY_CYC + 10);
    checkValue("busy_len", busyRun, BUSY_CYC);

    // Line wrap points
    sendByte(1'b0, 8'hC0);
    checkValue("set_c0", {25'd0, oDDRAMAddr}, 32'h40);
    waitIdle(BUSY_CYC + 10);
    sendByte(1'b0, 8'hA7);
    checkValue("set_a7", {25'd0, oDDRAMAddr}, 32'h27);
    waitIdle(BUSY_CYC + 10);
    sendByte(1'b1, 8'h58);
    checkValue("wrap_27", {25'd0, oDDRAMAddr}, 32'h40);
    waitIdle(BUSY_CYC + 10);
    sendByte(1'b0, 8'hE7);
    waitIdle(BUSY_CYC + 10);
    sendByte(1'b1, 8'h59);
    checkValue("wrap_67", {25'd0, oDDRAMAddr}, 32'h00);
    waitIdle(BUSY_CYC + 10);

    for (int i = 0; i < 5; i++) begin
      sendByte(1'b1, 8'h61 + 8'(i));
      waitIdle(BUSY_CYC + 10);
    end
    checkValue("five_writes", {25'd0, oDDRAMAddr}, 32'd5);

    sendByte(1'b0, 8'h01);
    checkValue("clear_addr", {25'd0, oDDRAMAddr}, 32'd0);
    waitIdle(CLEAR_CYC + 10);
    checkValue("clear_busy_len", busyRun, CLEAR_CYC);
    checkValue("clear_err", {31'd0, oProtocolError}, 32'd0);

    // Write during clear busy time: flagged but still decoded
    sendByte(1'b0, 8'h01);
    repeat (60) @(negedge Clock);
    checkValue("pre_busy_err", {31'd0, oProtocolError}, 32'd0);
    sendByte(1'b0, 8'h06);
    checkValue("busy_write_err", {31'd0, oProtocolError}, 32'd1);
    waitIdle(CLEAR_CYC + 10);

    // Read strobe leaves the INIT8 phase untouched
    doReset();
    writeNibble(1'b0, 1'b1, 4'h2, E_HIGH);
    checkValue("rw_err", {31'd0, oProtocolError}, 32'd1);
    checkValue("rw_4bit", {31'd0, oFourBitMode}, 32'd0);
    pushExpected(1'b0, 8'h20);
    writeNibble(1'b0, 1'b0, 4'h2, E_HIGH);
    checkValue("rw_then_4bit", {31'd0, oFourBitMode}, 32'd1);

    doReset();
    pushExpected(1'b0, 8'h30);
    writeNibble(1'b0, 1'b0, 4'h3, 5);
    checkValue("short_e_err", {31'd0, oProtocolError}, 32'd1);

    // RS mismatch between nibbles drops the byte and resyncs on the next strobe
    doReset();
    pushExpected(1'b0, 8'h20);
    writeNibble(1'b0, 1'b0, 4'h2, E_HIGH);
    waitIdle(BUSY_CYC + 10);
    checkValue("rs_pre_err", {31'd0, oProtocolError}, 32'd0);
    writeNibble(1'b0, 1'b0, 4'h4, E_HIGH);
    writeNibble(1'b1, 1'b0, 4'h1, E_HIGH);
    checkValue("rs_mismatch_err", {31'd0, oProtocolError}, 32'd1);
    sendByte(1'b1, 8'h42);
    checkValue("rs_resync_addr", {25'd0, oDDRAMAddr}, 32'd1);
    waitIdle(BUSY_CYC + 10);

    // Reset between high and low nibble
    doReset();
    pushExpected(1'b0, 8'h20);
    writeNibble(1'b0, 1'b0, 4'h2, E_HIGH);
    waitIdle(BUSY_CYC + 10);
    writeNibble(1'b1, 1'b0, 4'h4, E_HIGH);
    doReset();
    checkResetState("midrst");
    pushExpected(1'b0, 8'h20);
    writeNibble(1'b0, 1'b0, 4'h2, E_HIGH);
    checkValue("midrst_4bit", {31'd0, oFourBitMode}, 32'd1);
    waitIdle(BUSY_CYC + 10);

    checkValue("valid_count", validCount, pushCount);
    checkValue("sb_left", sbQueue.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
